fib_seq_gen: RTL

Parametrised Fibonacci-class sequence generator with a valid/ready output stream. Given a term count and two seed values, it produces terms 1..N of the recurrence T(k) = T(k-1) + T(k-2) at up to one term per cycle. Seeds (1,1) give Fibonacci and (2,1) give Lucas. Each term carries a sticky wrap flag. The block is the hardware sequence source for downstream checkers and display logic, replacing simulation-only recursive evaluation with an iterative datapath.

---
 rtl/fib_seq_gen_if.sv | 27 ++
 rtl/fib_seq_gen.sv | 93 +++++++++
 2 files changed

// File: rtl/fib_seq_gen_if.sv
// rtl/fib_seq_gen_if.sv - request and term-stream signals for the Fibonacci-class sequence generator
interface fib_seq_gen_if #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 8
);
    logic             START;
    logic [IDXW-1:0]  N;
    logic [WIDTH-1:0] SEED0;
    logic [WIDTH-1:0] SEED1;
    logic             BUSY;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_TERM;
    logic [IDXW-1:0]  OUT_INDEX;
    logic             OUT_OVF;
    logic             DONE;

    modport master (
        output START, N, SEED0, SEED1, OUT_READY,
        input  BUSY, OUT_VALID, OUT_TERM, OUT_INDEX, OUT_OVF, DONE
    );

    modport slave (
        input  START, N, SEED0, SEED1, OUT_READY,
        output BUSY, OUT_VALID, OUT_TERM, OUT_INDEX, OUT_OVF, DONE
    );
endinterface

// File: rtl/fib_seq_gen.sv
// rtl/fib_seq_gen.sv - iterative T(k)=T(k-1)+T(k-2) generator with a valid/ready term stream
module fib_seq_gen #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 8
) (
    input  logic          CLK,
    input  logic          RST_X,
    fib_seq_gen_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_FIN} state_t;

    state_t           state;
    logic [IDXW-1:0]  n_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] term_q;
    logic [WIDTH-1:0] next_q;
    logic             ovf_q;
    logic             ovf_next_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH:0]   sum;
    logic             hs;

    assign sum = {1'b0, term_q} + {1'b0, next_q};
    assign hs  = valid_q & bus.OUT_READY;

    // ovf_next_q travels with next_q so a carry is reported on the term the wrapped sum becomes
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state      <= S_IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            term_q     <= '0;
            next_q     <= '0;
            ovf_q      <= 1'b0;
            ovf_next_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.START) begin
                        n_q        <= bus.N;
                        ovf_q      <= 1'b0;
                        ovf_next_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (bus.N == '0) begin
                            state  <= S_FIN;
                            done_q <= 1'b1;
                        end else begin
                            state   <= S_EMIT;
                            valid_q <= 1'b1;
                            term_q  <= bus.SEED0;
                            next_q  <= bus.SEED1;
                            idx_q   <= IDXW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (hs) begin
                        if (idx_q == n_q) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= S_FIN;
                        end else begin
                            term_q     <= next_q;
                            idx_q      <= idx_q + IDXW'(1);
                            next_q     <= sum[WIDTH-1:0];
                            ovf_q      <= ovf_next_q;
                            ovf_next_q <= ovf_next_q | sum[WIDTH];
                        end
                    end
                end
                S_FIN: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.BUSY      = busy_q;
    assign bus.OUT_VALID = valid_q;
    assign bus.OUT_TERM  = term_q;
    assign bus.OUT_INDEX = idx_q;
    assign bus.OUT_OVF   = ovf_q;
    assign bus.DONE      = done_q;
endmodule
